// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Multiply is radix-2 shift-add and divide is restoring division, one bit
// per cycle. A request is accepted only in IDLE. The unit is busy for
// WIDTH+1 cycles and then pulses done for one cycle.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo write HI/LO here
// RUN   | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO write-back
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start, funct request strobe and R-type funct field
//   a, b         rs / rt operands
//   busy, done   operation in flight / one-cycle completion pulse
//   stall        start presented while busy
//   hi, lo       architectural HI/LO registers
//   rdata        mfhi/mflo read data (zero for any other funct)
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state, state_nx;

  logic [CNTW-1:0]  cnt;
  logic             op_div;
  logic             neg_res;   // quotient / product must be negated
  logic             neg_rem;   // remainder takes the dividend's sign
  logic             div0;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;    // partial product high half / remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend-quotient

  // request decode
  logic is_mul, is_div, is_signed, accept;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign accept    = (state == S_IDLE) && start && (is_mul || is_div);

  assign a_neg = is_signed && a[WIDTH-1];
  assign b_neg = is_signed && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // one shift-add step: add multiplicand if the current multiplier bit is
  // set, then shift {carry, sum, multiplier} right by one
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};

  // one restoring-divide step on the remainder shifted left with the next
  // dividend bit; the compare is done at WIDTH+1 bits so it cannot wrap
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;

  // sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == S_RUN) || (state == S_FIX);
  end

  assign stall = start && busy;

  always_comb begin
    case (funct)
      F_MFHI:  rdata = hi;
      F_MFLO:  rdata = lo;
      default: rdata = '0;
    endcase
  end

  // datapath and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt     <= '0;
            op_div  <= is_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (b == '0);
            opnd    <= mag_b;
            acc_hi  <= '0;
            acc_lo  <= mag_a;
          end else if (start && funct == F_MTHI) begin
            hi <= a;
          end else if (start && funct == F_MTLO) begin
            lo <= a;
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_ONE;
          if (op_div) begin
            acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (op_div) begin
            // with a zero divisor the remainder path already yields |a|,
            // which the dividend-sign fix turns back into a
            lo <= div0 ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit with architectural HI/LO registers, sitting beside the main ALU in the MIPS datapath.
- It decodes the R-type funct field directly for mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Multiply and divide run one bit per cycle, using radix-2 shift-add for multiply and restoring division for divide.
- The controller starts an operation with a start/busy/done handshake and stalls on the stall output.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>= 4)
CNTW, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request: execute funct this cycle
funct  input  6  R-type function field
a  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
b  input  WIDTH  rt operand (divisor / multiplier)
busy  output  1  high while an operation is in RUN or FIX
done  output  1  one-cycle pulse; HI/LO hold the new result
stall  output  1  combinational: start & busy
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
rdata  output  WIDTH  combinational: hi if funct==010000 (mfhi), lo if 010010 (mflo), else 0

Behaviour:
- Reset (synchronous, active-high, has priority over everything):
  - state=IDLE; hi=lo=0; done=0; counter=0; internal accumulators=0.
  - A reset mid-operation aborts the operation: no HI/LO write and no done pulse.
- Funct encodings: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011, mfhi 010000, mflo 010010.
- Accepting requests:
  - start is accepted only in IDLE.
  - start in RUN or FIX is ignored; stall=1 in that case.
  - The controller must hold start and funct until stall falls.
- mthi/mtlo accepted in IDLE: hi (or lo) <= a at that edge; no busy and no done.
- mfhi/mflo: no state change; rdata is valid in any state and shows the current (old) hi/lo while busy.
- Unrecognised funct with start: ignored and remains IDLE.
- States IDLE -> RUN -> FIX -> IDLE:
  - Accept edge E0: latch magnitudes of a and b (two's-complement abs for signed ops, raw for unsigned) and the result sign flags; counter=0; go to RUN.
  - RUN: one iteration per edge (E1..E_WIDTH); counter increments; at counter==WIDTH-1 go to FIX.
  - FIX, edge E_(WIDTH+1): apply sign correction, write hi/lo, done<=1, go to IDLE.
  - busy=1 for exactly WIDTH+1 cycles.
  - done=1 in the first IDLE cycle; a new start in that cycle is accepted.
- Multiply: 2*WIDTH-bit product {hi,lo}. Signed: negate the 2*WIDTH-bit product if the operand signs differ.
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): lo = all ones, hi = a. Same latency.
- Signed MIN / -1: lo = MIN (0x80000000 at W=32), hi = 0. No exception.
- done is registered and is never high in the same cycle as busy.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF, start at E0:
  - busy high 33 cycles, done pulse in the cycle after E33.
  - hi=0xFFFFFFFE, lo=0x00000001.
- mult a=-6 (0xFFFFFFFA) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. Back-to-back: a new start issued in the done cycle is accepted.
- div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=0x00001234 b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after 33 busy cycles.
- During busy:
  - start/mflo gives stall=1 and rdata=old lo.
  - start/multu is ignored; the result matches the first operation only.
- Sequencing and reset:
  - mthi a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy/done stay 0.
  - Then divu, with reset asserted at RUN counter=10 -> busy=0, hi=lo=0, no done pulse.
